// File: rtl/ece571_cpu_pkg.sv
// Shared CPU types: instruction packet, ALU opcodes, issue FSM states and the
// opcode legality helper used by the issue sequencer.
package ece571_cpu_pkg;

    localparam int N       = 32;
    localparam int IMM_BIT = 7;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100
    } opcode_t;

    // Field order puts the immediate flag at bit IMM_BIT of the packet.
    typedef struct packed {
        logic [N-1:0] data;
        logic [3:0]   rs1;
        logic [3:0]   rs2;
        logic         we;
        logic         imm;
        logic [3:0]   rd;
        opcode_t      op;
    } alu_instruction;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } issue_state_t;

    function automatic logic is_legal_op(opcode_t op);
        return (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR});
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_fifo.sv
// Synchronous show-ahead FIFO holding pending ALU instructions.
// Pushes are ignored while full and pops while empty.
module alu_instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_wdata,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue sequencer: buffers instructions and walks each through READ/EXEC/WB.
// Defining ALU_ISSUE_PERF_EN adds saturating retired/illegal counters.
module alu_issue_ctrl
    import ece571_cpu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  alu_instruction in_instr,
    output logic [3:0]     rf_raddr1,
    output logic [3:0]     rf_raddr2,
    input  logic [N-1:0]   rf_rdata1,
    input  logic [N-1:0]   rf_rdata2,
    output logic [N-1:0]   alu_a,
    output logic [N-1:0]   alu_b,
    output logic [2:0]     alu_op,
    input  logic [N-1:0]   alu_result,
    output logic           rf_we,
    output logic [3:0]     rf_waddr,
    output logic [N-1:0]   rf_wdata,
    output logic           busy,
    output logic           err_illegal,
`ifdef ALU_ISSUE_PERF_EN
    output logic [15:0]    retired_cnt,
    output logic [15:0]    illegal_cnt,
`endif
    output logic [1:0]     dbg_state
);

    issue_state_t              r_state;
    issue_state_t              w_next_state;
    alu_instruction            r_instr;
    alu_instruction            w_fifo_rdata;
    opcode_t                   r_op;
    logic [N-1:0]              r_op_a;
    logic [N-1:0]              r_op_b;
    logic [N-1:0]              r_result;
    logic                      w_fifo_full;
    logic                      w_fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] w_fifo_count;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_capture;

    assign w_push   = in_valid && !w_fifo_full;
    assign in_ready = !w_fifo_full;

    alu_instr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(alu_instruction))
    ) u_fifo (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (in_instr),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_capture    = 1'b0;
        err_illegal  = 1'b0;
        rf_we        = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = READ;
                end
            end
            READ: begin
                if (!is_legal_op(r_instr.op)) begin
                    err_illegal  = 1'b1;
                    w_pop        = !w_fifo_empty;
                    w_next_state = w_fifo_empty ? IDLE : READ;
                end else begin
                    w_capture    = 1'b1;
                    w_next_state = EXEC;
                end
            end
            EXEC: w_next_state = WB;
            WB: begin
                rf_we        = r_instr.we && (r_instr.rd != 4'd0);
                w_pop        = !w_fifo_empty;
                w_next_state = w_fifo_empty ? IDLE : READ;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Operands are only captured for legal ops so the ALU inputs hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr  <= '0;
            r_op     <= OP_ADD;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_result <= '0;
        end else begin
            if (w_pop) r_instr <= w_fifo_rdata;
            if (w_capture) begin
                r_op_a <= rf_rdata1;
                r_op_b <= r_instr[IMM_BIT] ? r_instr.data : rf_rdata2;
                r_op   <= r_instr.op;
            end
            if (r_state == EXEC) r_result <= alu_result;
        end
    end

    assign rf_raddr1 = r_instr.rs1;
    assign rf_raddr2 = r_instr.rs2;
    assign alu_a     = r_op_a;
    assign alu_b     = r_op_b;
    assign alu_op    = r_op;
    assign rf_waddr  = r_instr.rd;
    assign rf_wdata  = r_result;
    assign busy      = (r_state != IDLE) || (w_fifo_count != '0);
    assign dbg_state = r_state;

`ifdef ALU_ISSUE_PERF_EN
    logic [15:0] r_retired_cnt;
    logic [15:0] r_illegal_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_retired_cnt <= '0;
            r_illegal_cnt <= '0;
        end else begin
            if (r_state == WB && r_retired_cnt != 16'hFFFF)
                r_retired_cnt <= r_retired_cnt + 1'b1;
            if (err_illegal && r_illegal_cnt != 16'hFFFF)
                r_illegal_cnt <= r_illegal_cnt + 1'b1;
        end
    end

    assign retired_cnt = r_retired_cnt;
    assign illegal_cnt = r_illegal_cnt;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: register-file and ALU models around
// the DUT, a vector table of single instructions, and multi-cycle sequences.
module tb_alu_issue_ctrl;
    import ece571_cpu_pkg::*;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    alu_instruction in_instr;
    logic [3:0]     rf_raddr1, rf_raddr2, rf_waddr;
    logic [31:0]    rf_rdata1, rf_rdata2, alu_a, alu_b, alu_result, rf_wdata;
    logic [2:0]     alu_op;
    logic           rf_we, busy, err_illegal;
    logic [1:0]     dbg_state;
`ifdef ALU_ISSUE_PERF_EN
    logic [15:0]    retired_cnt, illegal_cnt;
`endif

    always #5 clk = ~clk;

    alu_issue_ctrl #(.FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .rf_raddr1   (rf_raddr1),
        .rf_raddr2   (rf_raddr2),
        .rf_rdata1   (rf_rdata1),
        .rf_rdata2   (rf_rdata2),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .busy        (busy),
        .err_illegal (err_illegal),
`ifdef ALU_ISSUE_PERF_EN
        .retired_cnt (retired_cnt),
        .illegal_cnt (illegal_cnt),
`endif
        .dbg_state   (dbg_state)
    );

    // Register file and ALU environment models
    logic [31:0] rf [16];

    function automatic logic [31:0] rf_init(input int i);
        case (i)
            1:       return 32'd5;
            2:       return 32'd7;
            4:       return 32'hFF;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) rf[i] <= rf_init(i);
        end else if (rf_we) begin
            rf[rf_waddr] <= rf_wdata;
        end
    end

    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];

    always_comb begin
        case (alu_op)
            3'b000:  alu_result = alu_a + alu_b;
            3'b001:  alu_result = alu_a - alu_b;
            3'b010:  alu_result = alu_a & alu_b;
            3'b011:  alu_result = alu_a | alu_b;
            3'b100:  alu_result = alu_a ^ alu_b;
            default: alu_result = 32'd0;
        endcase
    end

    // Monitor: records every write and counts err_illegal cycles
    logic [35:0] obs_q[$];
    int          ill_cnt = 0;

    always @(negedge clk) begin
        if (rf_we) obs_q.push_back({rf_waddr, rf_wdata});
        if (err_illegal) ill_cnt++;
    end

    // Scoreboard
    logic [35:0] exp_q[$];
    int          obs_rd = 0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drain(input string tag);
        while (obs_rd < obs_q.size()) begin
            if (exp_q.size() == 0) begin
                chk({tag, "_unexpected_write"}, 64'(obs_q[obs_rd]), 64'd0);
            end else begin
                chk({tag, "_write"}, 64'(obs_q[obs_rd]), 64'(exp_q.pop_front()));
            end
            obs_rd++;
        end
        chk({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
    endtask

    function automatic alu_instruction mk(input logic [2:0] op, input logic [3:0] rs1,
                                          input logic [3:0] rs2, input logic [3:0] rd,
                                          input logic we, input logic imm,
                                          input logic [31:0] data);
        alu_instruction p;
        p.op   = opcode_t'(op);
        p.rs1  = rs1;
        p.rs2  = rs2;
        p.rd   = rd;
        p.we   = we;
        p.imm  = imm;
        p.data = data;
        return p;
    endfunction

    task automatic push(input alu_instruction p, output int stall);
        stall    = 0;
        in_instr = p;
        in_valid = 1'b1;
        while (!in_ready && stall < 100) begin
            @(posedge clk);
            #1;
            stall++;
        end
        if (!in_ready) chk("push_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", 64'(busy), 64'd0);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [3:0]  rs1, rs2, rd;
        logic        we, imm;
        logic [31:0] data;
        logic        exp_we;
        logic [31:0] exp_wdata;
        int          exp_ill;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int st;
        int obs_base;
        int ill_base;
        int stall_sum;

        vecs[0]  = '{3'b000, 4'd1, 4'd2, 4'd3,  1'b1, 1'b0, 32'h0,        1'b1, 32'd12,        0};
        vecs[1]  = '{3'b001, 4'd2, 4'd1, 4'd6,  1'b1, 1'b0, 32'h0,        1'b1, 32'd2,         0};
        vecs[2]  = '{3'b010, 4'd4, 4'd0, 4'd7,  1'b1, 1'b1, 32'h3C,       1'b1, 32'h3C,        0};
        vecs[3]  = '{3'b011, 4'd1, 4'd2, 4'd8,  1'b1, 1'b0, 32'h0,        1'b1, 32'd7,         0};
        vecs[4]  = '{3'b100, 4'd4, 4'd0, 4'd5,  1'b1, 1'b1, 32'h0F,       1'b1, 32'hF0,        0};
        vecs[5]  = '{3'b100, 4'd4, 4'd0, 4'd0,  1'b1, 1'b1, 32'h0F,       1'b0, 32'h0,         0};
        vecs[6]  = '{3'b000, 4'd1, 4'd2, 4'd9,  1'b0, 1'b0, 32'h0,        1'b0, 32'h0,         0};
        vecs[7]  = '{3'b101, 4'd1, 4'd2, 4'd10, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,         1};
        vecs[8]  = '{3'b110, 4'd1, 4'd2, 4'd10, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,         1};
        vecs[9]  = '{3'b001, 4'd1, 4'd2, 4'd10, 1'b1, 1'b0, 32'h0,        1'b1, 32'hFFFFFFFE,  0};
        vecs[10] = '{3'b000, 4'd4, 4'd0, 4'd11, 1'b1, 1'b1, 32'hFFFFFF01, 1'b1, 32'h0,         0};
        vecs[11] = '{3'b111, 4'd1, 4'd2, 4'd3,  1'b1, 1'b0, 32'h0,        1'b0, 32'h0,         1};

        rst      = 1'b1;
        in_valid = 1'b0;
        in_instr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rf_we", 64'(rf_we), 64'd0);
        chk("rst_err_illegal", 64'(err_illegal), 64'd0);
        chk("rst_alu_a", 64'(alu_a), 64'd0);
        chk("rst_rf_wdata", 64'(rf_wdata), 64'd0);
        chk("rst_state", 64'(dbg_state), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Latency: accept in cycle C, write strobe in cycle C+4
        exp_q.push_back({4'd3, 32'd12});
        in_instr = mk(3'b000, 4'd1, 4'd2, 4'd3, 1'b1, 1'b0, 32'h0);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk($sformatf("lat_we_c%0d", k), 64'(rf_we), 64'(k == 4));
            chk($sformatf("lat_state_c%0d", k), 64'(dbg_state), 64'(k - 1));
        end
        chk("lat_waddr", 64'(rf_waddr), 64'd3);
        chk("lat_wdata", 64'(rf_wdata), 64'd12);
        wait_idle();
        drain("latency");

        // Table of single instructions issued from idle
        for (int v = 0; v < 12; v++) begin
            obs_base = obs_q.size();
            ill_base = ill_cnt;
            if (vecs[v].exp_we) exp_q.push_back({vecs[v].rd, vecs[v].exp_wdata});
            push(mk(vecs[v].op, vecs[v].rs1, vecs[v].rs2, vecs[v].rd,
                    vecs[v].we, vecs[v].imm, vecs[v].data), st);
            wait_idle();
            chk($sformatf("v%0d_writes", v), 64'(obs_q.size() - obs_base), 64'(vecs[v].exp_we));
            chk($sformatf("v%0d_illegal", v), 64'(ill_cnt - ill_base), 64'(vecs[v].exp_ill));
            drain($sformatf("v%0d", v));
        end

        // Burst of seven: FIFO fills, the seventh waits through a WB pop
        stall_sum = 0;
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back({4'(9 + i), 32'(5 + 3 * i)});
            push(mk(3'b000, 4'd1, 4'd0, 4'(9 + i), 1'b1, 1'b1, 32'(3 * i)), st);
            if (i < 6) stall_sum += st;
            if (i == 5) chk("burst_full_ready", 64'(in_ready), 64'd0);
            if (i == 6) chk("burst_held_cycles", 64'(st), 64'd2);
        end
        chk("burst_early_stalls", 64'(stall_sum), 64'd0);
        wait_idle();
        drain("burst");

        // Illegal opcode between two SUBs
        ill_base = ill_cnt;
        exp_q.push_back({4'd12, 32'd2});
        exp_q.push_back({4'd13, 32'hF0});
        push(mk(3'b001, 4'd2, 4'd1, 4'd12, 1'b1, 1'b0, 32'h0), st);
        push(mk(3'b111, 4'd1, 4'd2, 4'd14, 1'b1, 1'b0, 32'h0), st);
        push(mk(3'b001, 4'd4, 4'd0, 4'd13, 1'b1, 1'b1, 32'h0F), st);
        wait_idle();
        chk("sandwich_illegal_pulses", 64'(ill_cnt - ill_base), 64'd1);
        drain("sandwich");

        // Reset while the instruction sits in EXEC
        obs_base = obs_q.size();
        push(mk(3'b000, 4'd1, 4'd2, 4'd14, 1'b1, 1'b0, 32'h0), st);
        begin
            int n = 0;
            @(negedge clk);
            while (dbg_state != 2'd2 && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("rst_exec_reached", 64'(dbg_state), 64'd2);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_state", 64'(dbg_state), 64'd0);
        chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
        repeat (10) @(negedge clk);
        chk("rst_mid_no_write", 64'(obs_q.size() - obs_base), 64'd0);
        drain("rst_mid");

`ifdef ALU_ISSUE_PERF_EN
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("perf_rst_retired", 64'(retired_cnt), 64'd0);
        chk("perf_rst_illegal", 64'(illegal_cnt), 64'd0);
        exp_q.push_back({4'd3, 32'd12});
        exp_q.push_back({4'd6, 32'd2});
        exp_q.push_back({4'd7, 32'h3C});
        push(mk(3'b000, 4'd1, 4'd2, 4'd3, 1'b1, 1'b0, 32'h0), st);
        push(mk(3'b110, 4'd1, 4'd2, 4'd3, 1'b1, 1'b0, 32'h0), st);
        push(mk(3'b001, 4'd2, 4'd1, 4'd6, 1'b1, 1'b0, 32'h0), st);
        push(mk(3'b010, 4'd4, 4'd0, 4'd7, 1'b1, 1'b1, 32'h3C), st);
        wait_idle();
        chk("perf_retired", 64'(retired_cnt), 64'd3);
        chk("perf_illegal", 64'(illegal_cnt), 64'd1);
        drain("perf");
        force dut.r_retired_cnt = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut.r_retired_cnt;
        exp_q.push_back({4'd8, 32'd7});
        exp_q.push_back({4'd8, 32'd7});
        push(mk(3'b011, 4'd1, 4'd2, 4'd8, 1'b1, 1'b0, 32'h0), st);
        wait_idle();
        chk("perf_reach_max", 64'(retired_cnt), 64'hFFFF);
        push(mk(3'b011, 4'd1, 4'd2, 4'd8, 1'b1, 1'b0, 32'h0), st);
        wait_idle();
        chk("perf_saturate", 64'(retired_cnt), 64'hFFFF);
        drain("perf_sat");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
